axi_fourchan_tier1_a32_d32_packet_master_skid: RTL and testbench

Master-end AXI fourchan tier1 (a32/d32 packet) adapter for the logic link.
- Packs the user AR/AW/W channels into tx FIFO words and unpacks the rx FIFO R/B words, using the same packet layout the slave end expects.
- Every channel passes through a 2-entry registered skid buffer, so both sides see registered valid/ready.
- A write-outstanding limiter throttles AW against returned B responses.

---
 rtl/axi_fourchan_tier1_a32_d32_packet_master_skid.sv | 204 ++++++++++++++++++++
 tb/tb_axi_fourchan_tier1_a32_d32_packet_master_skid.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fourchan_tier1_a32_d32_packet_master_skid.sv
// ---------------------------------------------------------------------------
// axi_fourchan_tier1_a32_d32_packet_master_skid
//
// Master-end AXI adapter for the logic link. User AR/AW/W requests are packed
// into tx FIFO words, and rx FIFO R/B words are unpacked into user responses.
// Every channel goes through a 2-entry registered skid buffer. A limiter holds
// back AW once OUTSTD_MAX writes are waiting for their B response.
//
// Ports:
//   clk_wr, rst_wr_n                : clock and asynchronous active-low reset
//   user_ar* / user_aw* / user_w*   : AXI master request channels (in)
//   user_r* / user_b*               : AXI responses to the master (out)
//   user_ar_vld/txfifo_ar_data      : link AR word {addr,burst,len,size,id}
//   user_aw_vld/txfifo_aw_data      : link AW word, same layout as AR
//   user_w_vld/txfifo_w_data        : link W word {last,data,id}
//   user_r_vld/rxfifo_r_data        : link R word {resp,last,data,id}
//   user_b_vld/rxfifo_b_data        : link B word {resp,id}
//   wr_outstd_cnt                   : writes accepted and not yet answered
//
// Build option: define RX_SKID_BYPASS_EN to drop the R and B skid buffers
// and make the rx path purely combinational.
// ---------------------------------------------------------------------------

// Two-entry FIFO-ordered skid buffer. Output data comes straight from the
// storage registers, so there is no combinational path from input to output.
module axi_fourchan_tier1_a32_d32_packet_master_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              push;
  logic              pop;

  assign in_ready = (cnt != 2'd2);
  assign out_vld  = (cnt != 2'd0);
  assign push     = in_vld & in_ready;
  assign pop      = out_vld & out_ready;
  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      // With one entry held, wr_ptr points at the free slot, so a push never
      // disturbs the entry being presented.
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module axi_fourchan_tier1_a32_d32_packet_master_skid #(
  parameter int OUTSTD_MAX = 16,
  parameter int CW         = $clog2(OUTSTD_MAX + 1)
) (
  input  logic          clk_wr,
  input  logic          rst_wr_n,
  input  logic [3:0]    user_arid,
  input  logic [1:0]    user_arsize,
  input  logic [7:0]    user_arlen,
  input  logic [1:0]    user_arburst,
  input  logic [47:0]   user_araddr,
  input  logic          user_arvalid,
  output logic          user_arready,
  input  logic [3:0]    user_awid,
  input  logic [1:0]    user_awsize,
  input  logic [7:0]    user_awlen,
  input  logic [1:0]    user_awburst,
  input  logic [47:0]   user_awaddr,
  input  logic          user_awvalid,
  output logic          user_awready,
  input  logic [3:0]    user_wid,
  input  logic [63:0]   user_wdata,
  input  logic          user_wlast,
  input  logic          user_wvalid,
  output logic          user_wready,
  output logic [3:0]    user_rid,
  output logic [63:0]   user_rdata,
  output logic          user_rlast,
  output logic [1:0]    user_rresp,
  output logic          user_rvalid,
  input  logic          user_rready,
  output logic [3:0]    user_bid,
  output logic [1:0]    user_bresp,
  output logic          user_bvalid,
  input  logic          user_bready,
  output logic          user_ar_vld,
  output logic [63:0]   txfifo_ar_data,
  input  logic          user_ar_ready,
  output logic          user_aw_vld,
  output logic [63:0]   txfifo_aw_data,
  input  logic          user_aw_ready,
  output logic          user_w_vld,
  output logic [68:0]   txfifo_w_data,
  input  logic          user_w_ready,
  input  logic          user_r_vld,
  input  logic [70:0]   rxfifo_r_data,
  output logic          user_r_ready,
  input  logic          user_b_vld,
  input  logic [5:0]    rxfifo_b_data,
  output logic          user_b_ready,
  output logic [CW-1:0] wr_outstd_cnt
);
  logic [CW-1:0] outstd;
  logic          aw_in_ready;
  logic          limit_hit;
  logic          aw_push;
  logic          b_hs;

  // ---- tx path: pack at buffer input ----
  axi_fourchan_tier1_a32_d32_packet_master_skid_buf #(.DATA_W(64)) u_ar (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_vld(user_arvalid), .in_ready(user_arready),
    .in_data({user_araddr, user_arburst, user_arlen, user_arsize, user_arid}),
    .out_vld(user_ar_vld), .out_ready(user_ar_ready), .out_data(txfifo_ar_data)
  );

  // The limiter must also gate the push itself, not only the ready shown to
  // the master, otherwise a full limiter could still let a beat in.
  axi_fourchan_tier1_a32_d32_packet_master_skid_buf #(.DATA_W(64)) u_aw (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_vld(user_awvalid & ~limit_hit), .in_ready(aw_in_ready),
    .in_data({user_awaddr, user_awburst, user_awlen, user_awsize, user_awid}),
    .out_vld(user_aw_vld), .out_ready(user_aw_ready), .out_data(txfifo_aw_data)
  );

  axi_fourchan_tier1_a32_d32_packet_master_skid_buf #(.DATA_W(69)) u_w (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_vld(user_wvalid), .in_ready(user_wready),
    .in_data({user_wlast, user_wdata, user_wid}),
    .out_vld(user_w_vld), .out_ready(user_w_ready), .out_data(txfifo_w_data)
  );

  // ---- rx path: unpack at buffer output ----
`ifdef RX_SKID_BYPASS_EN
  assign user_rvalid  = user_r_vld;
  assign user_r_ready = user_rready;
  assign {user_rresp, user_rlast, user_rdata, user_rid} = rxfifo_r_data;
  assign user_bvalid  = user_b_vld;
  assign user_b_ready = user_bready;
  assign {user_bresp, user_bid} = rxfifo_b_data;
`else
  axi_fourchan_tier1_a32_d32_packet_master_skid_buf #(.DATA_W(71)) u_r (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_vld(user_r_vld), .in_ready(user_r_ready), .in_data(rxfifo_r_data),
    .out_vld(user_rvalid), .out_ready(user_rready),
    .out_data({user_rresp, user_rlast, user_rdata, user_rid})
  );

  axi_fourchan_tier1_a32_d32_packet_master_skid_buf #(.DATA_W(6)) u_b (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .in_vld(user_b_vld), .in_ready(user_b_ready), .in_data(rxfifo_b_data),
    .out_vld(user_bvalid), .out_ready(user_bready),
    .out_data({user_bresp, user_bid})
  );
`endif

  // ---- write-outstanding limiter ----
  assign limit_hit     = (outstd == CW'(OUTSTD_MAX));
  assign user_awready  = aw_in_ready & ~limit_hit;
  assign aw_push       = user_awvalid & user_awready;
  assign b_hs          = user_bvalid & user_bready;
  assign wr_outstd_cnt = outstd;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      outstd <= '0;
    end else if (aw_push && !b_hs) begin
      outstd <= outstd + CW'(1);
    end else if (b_hs && !aw_push && (outstd != '0)) begin
      // A B with nothing outstanding is a protocol error; the count holds at 0.
      outstd <= outstd - CW'(1);
    end
  end

`ifndef SYNTHESIS
  b_underflow_a: assert property (@(posedge clk_wr) disable iff (!rst_wr_n)
    !(b_hs && !aw_push && (outstd == '0)));
`endif

endmodule

// File: tb/tb_axi_fourchan_tier1_a32_d32_packet_master_skid.sv
module tb_axi_fourchan_tier1_a32_d32_packet_master_skid;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic clk_wr = 1'b0;
  logic rst_wr_n = 1'b0;
  logic [3:0] user_arid = '0, user_awid = '0, user_wid = '0;
  logic [1:0] user_arsize = '0, user_arburst = '0, user_awsize = '0, user_awburst = '0;
  logic [7:0] user_arlen = '0, user_awlen = '0;
  logic [47:0] user_araddr = '0, user_awaddr = '0;
  logic user_arvalid = 0, user_awvalid = 0, user_wvalid = 0, user_wlast = 0;
  logic [63:0] user_wdata = '0;
  logic user_arready, user_awready, user_wready;
  logic [3:0] user_rid, user_bid;
  logic [63:0] user_rdata;
  logic user_rlast, user_rvalid, user_bvalid;
  logic [1:0] user_rresp, user_bresp;
  logic user_rready = 1, user_bready = 1;
  logic user_ar_vld, user_aw_vld, user_w_vld;
  logic [63:0] txfifo_ar_data, txfifo_aw_data;
  logic [68:0] txfifo_w_data;
  logic user_ar_ready = 1, user_aw_ready = 1, user_w_ready = 1;
  logic user_r_vld = 0, user_b_vld = 0;
  logic [70:0] rxfifo_r_data = '0;
  logic [5:0] rxfifo_b_data = '0;
  logic user_r_ready, user_b_ready;
  logic [CW-1:0] wr_outstd_cnt;

  int vectors = 0;
  int miscompares = 0;

  axi_fourchan_tier1_a32_d32_packet_master_skid #(.OUTSTD_MAX(MAXO)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
    .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
    .user_arburst(user_arburst), .user_araddr(user_araddr),
    .user_arvalid(user_arvalid), .user_arready(user_arready),
    .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
    .user_awburst(user_awburst), .user_awaddr(user_awaddr),
    .user_awvalid(user_awvalid), .user_awready(user_awready),
    .user_wid(user_wid), .user_wdata(user_wdata), .user_wlast(user_wlast),
    .user_wvalid(user_wvalid), .user_wready(user_wready),
    .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
    .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
    .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
    .user_bready(user_bready),
    .user_ar_vld(user_ar_vld), .txfifo_ar_data(txfifo_ar_data), .user_ar_ready(user_ar_ready),
    .user_aw_vld(user_aw_vld), .txfifo_aw_data(txfifo_aw_data), .user_aw_ready(user_aw_ready),
    .user_w_vld(user_w_vld), .txfifo_w_data(txfifo_w_data), .user_w_ready(user_w_ready),
    .user_r_vld(user_r_vld), .rxfifo_r_data(rxfifo_r_data), .user_r_ready(user_r_ready),
    .user_b_vld(user_b_vld), .rxfifo_b_data(rxfifo_b_data), .user_b_ready(user_b_ready),
    .wr_outstd_cnt(wr_outstd_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic [3:0] id; logic [1:0] size; logic [7:0] len; logic [1:0] burst;
    logic [47:0] addr; logic [63:0] exp;
  } a_vec_t;
  typedef struct {
    logic [70:0] word; logic [3:0] id; logic [63:0] data; logic last; logic [1:0] resp;
  } r_vec_t;

  a_vec_t av[4];
  r_vec_t rv[3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  function automatic logic [63:0] pk_a(logic [3:0] id, logic [1:0] size, logic [7:0] len,
                                        logic [1:0] burst, logic [47:0] addr);
    return {addr, burst, len, size, id};
  endfunction

  task automatic idle_inputs();
    user_arvalid = 0; user_awvalid = 0; user_wvalid = 0;
    user_r_vld = 0; user_b_vld = 0;
    user_ar_ready = 1; user_aw_ready = 1; user_w_ready = 1;
    user_rready = 1; user_bready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_wr_n = 0;
    @(negedge clk_wr);
    rst_wr_n = 1;
    tick();
  endtask

  task automatic set_aw(input logic [3:0] id);
    user_awid = id; user_awsize = 2'd3; user_awlen = 8'(id);
    user_awburst = 2'd1; user_awaddr = 48'(id) << 8;
  endtask

  // one B word through the rx path with the master ready
  task automatic send_b(input logic [3:0] id);
    user_bready = 1; user_b_vld = 1; rxfifo_b_data = {2'b00, id};
`ifdef RX_SKID_BYPASS_EN
    chk("b_vld_bypass", user_bvalid, 1);
    tick();
    user_b_vld = 0;
`else
    tick();
    user_b_vld = 0;
    chk("b_vld", user_bvalid, 1);
    chk("b_id", user_bid, id);
    tick();
`endif
  endtask

  // scoreboard state for the random phase
  logic [63:0] q_ar[$], q_aw[$];
  logic [68:0] q_w[$];
  logic [70:0] q_r[$];
  logic [5:0]  q_b[$];
  int cnt_m, aw_acc, b_inj;

  task automatic chan_chk(input string nm, input int sz, input logic vld,
                          input logic [127:0] data, input logic [127:0] head,
                          input logic rdy, input logic exp_rdy);
    chk({nm, "_vld"}, vld, sz != 0);
    if (sz != 0) chk({nm, "_data"}, data, head);
    chk({nm, "_rdy"}, rdy, exp_rdy);
  endtask

  initial begin
    int idx, got;
    logic ar_pop, aw_pop, w_pop, r_pop, b_pop;
    logic ar_push, aw_push, w_push, r_push, b_push;

    av[0] = '{4'h3, 2'd2, 8'h07, 2'd1, 48'h0000_1234_5678, 64'h0000_1234_5678_41E3};
    av[1] = '{4'hF, 2'd3, 8'hFF, 2'd3, 48'hFFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    av[2] = '{4'h0, 2'd0, 8'h00, 2'd0, 48'h0,              64'h0};
    av[3] = '{4'hA, 2'd1, 8'h80, 2'd2, 48'h8000_0000_0001, 64'h8000_0000_0001_A01A};
    rv[0] = '{{2'd2, 1'b1, 64'hDEAD_BEEF_0123_4567, 4'd5}, 4'd5, 64'hDEAD_BEEF_0123_4567, 1'b1, 2'd2};
    rv[1] = '{{2'd0, 1'b0, 64'h0000_0000_0000_0001, 4'd0}, 4'd0, 64'h1, 1'b0, 2'd0};
    rv[2] = '{{2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF}, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd3};

    // reset state
    #3;
    chk("rst_ar_vld", user_ar_vld, 0);
    chk("rst_aw_vld", user_aw_vld, 0);
    chk("rst_w_vld", user_w_vld, 0);
    chk("rst_arready", user_arready, 1);
    chk("rst_awready", user_awready, 1);
    chk("rst_wready", user_wready, 1);
    chk("rst_cnt", wr_outstd_cnt, 0);
    chk("rst_ar_data", txfifo_ar_data, 0);
    chk("rst_w_data", txfifo_w_data, 0);
`ifndef RX_SKID_BYPASS_EN
    chk("rst_rvalid", user_rvalid, 0);
    chk("rst_bvalid", user_bvalid, 0);
    chk("rst_r_ready", user_r_ready, 1);
    chk("rst_b_ready", user_b_ready, 1);
    chk("rst_rdata", user_rdata, 0);
`endif
    @(negedge clk_wr);
    rst_wr_n = 1;
    tick();

    // AR/AW packing table
    for (int i = 0; i < 4; i++) begin
      user_arid = av[i].id; user_arsize = av[i].size; user_arlen = av[i].len;
      user_arburst = av[i].burst; user_araddr = av[i].addr;
      user_awid = av[i].id; user_awsize = av[i].size; user_awlen = av[i].len;
      user_awburst = av[i].burst; user_awaddr = av[i].addr;
      user_arvalid = 1; user_awvalid = 1;
      tick();
      user_arvalid = 0; user_awvalid = 0;
      chk($sformatf("tab_ar_vld%0d", i), user_ar_vld, 1);
      chk($sformatf("tab_ar_data%0d", i), txfifo_ar_data, av[i].exp);
      chk($sformatf("tab_aw_data%0d", i), txfifo_aw_data, av[i].exp);
      tick();
      chk($sformatf("tab_ar_empty%0d", i), user_ar_vld, 0);
    end
    do_reset();

    // R unpack table
    for (int i = 0; i < 3; i++) begin
      user_r_vld = 1; rxfifo_r_data = rv[i].word;
`ifndef RX_SKID_BYPASS_EN
      tick();
      user_r_vld = 0;
`endif
      chk($sformatf("tab_rvalid%0d", i), user_rvalid, 1);
      chk($sformatf("tab_rid%0d", i), user_rid, rv[i].id);
      chk($sformatf("tab_rdata%0d", i), user_rdata, rv[i].data);
      chk($sformatf("tab_rlast%0d", i), user_rlast, rv[i].last);
      chk($sformatf("tab_rresp%0d", i), user_rresp, rv[i].resp);
      user_r_vld = 0;
      tick();
    end

    // W streaming, link ready held high
    user_wid = 4'h6;
    for (int i = 0; i < 8; i++) begin
      user_wvalid = 1; user_wdata = 64'(i); user_wlast = (i == 7);
      chk($sformatf("wstream_wready%0d", i), user_wready, 1);
      tick();
      chk($sformatf("wstream_vld%0d", i), user_w_vld, 1);
      chk($sformatf("wstream_data%0d", i), txfifo_w_data, {(i == 7), 64'(i), 4'h6});
    end
    user_wvalid = 0; user_wlast = 0;
    tick();
    chk("wstream_done", user_w_vld, 0);

    // AW back-pressure then drain in order
    user_aw_ready = 0; idx = 0;
    for (int c = 0; c < 4; c++) begin
      set_aw(4'(idx)); user_awvalid = 1;
      chk($sformatf("bp_awready%0d", c), user_awready, c < 2);
      if (user_awready) idx++;
      tick();
    end
    chk("bp_accepted", idx, 2);
    user_aw_ready = 1; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      set_aw(4'(idx)); user_awvalid = (idx < 4);
      if (user_aw_vld) begin
        chk($sformatf("bp_drain%0d", got), txfifo_aw_data,
            pk_a(4'(got), 2'd3, 8'(got), 2'd1, 48'(got) << 8));
        got++;
      end
      if (user_awvalid && user_awready) idx++;
      tick();
    end
    chk("bp_drained", got, 4);
    do_reset();

    // Limiter with OUTSTD_MAX=4
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      set_aw(4'(idx)); user_awvalid = (idx < 5);
      if (user_awvalid && user_awready) idx++;
      tick();
    end
    user_awvalid = 0;
    chk("lim_accepted", idx, 4);
    chk("lim_cnt4", wr_outstd_cnt, 4);
    chk("lim_awready0", user_awready, 0);
    send_b(4'd0);
    chk("lim_cnt3", wr_outstd_cnt, 3);
    chk("lim_awready1", user_awready, 1);
    set_aw(4'd4); user_awvalid = 1;
    tick();
    user_awvalid = 0;
    chk("lim_5th_cnt", wr_outstd_cnt, 4);
    send_b(4'd1);
    chk("lim_cnt3b", wr_outstd_cnt, 3);
    // AW push and B handshake on the same edge
`ifdef RX_SKID_BYPASS_EN
    user_b_vld = 1; rxfifo_b_data = 6'd2; user_bready = 1;
`else
    user_bready = 0; user_b_vld = 1; rxfifo_b_data = 6'd2;
    tick();
    user_b_vld = 0;
    tick();
    chk("lim_b_held", user_bvalid, 1);
    user_bready = 1;
`endif
    set_aw(4'd5); user_awvalid = 1;
    chk("lim_same_awready", user_awready, 1);
    tick();
    user_awvalid = 0; user_b_vld = 0;
    chk("lim_same_cnt", wr_outstd_cnt, 3);
    do_reset();

    // Randomized traffic against a queue model
    cnt_m = 0; aw_acc = 0; b_inj = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_wr); #1;
      user_arvalid = ($urandom_range(0, 99) < 60);
      user_arid = 4'($urandom); user_arsize = 2'($urandom); user_arlen = 8'($urandom);
      user_arburst = 2'($urandom); user_araddr = 48'({$urandom, $urandom});
      user_awvalid = ($urandom_range(0, 99) < 50);
      user_awid = 4'($urandom); user_awsize = 2'($urandom); user_awlen = 8'($urandom);
      user_awburst = 2'($urandom); user_awaddr = 48'({$urandom, $urandom});
      user_wvalid = ($urandom_range(0, 99) < 60);
      user_wid = 4'($urandom); user_wdata = {$urandom, $urandom}; user_wlast = 1'($urandom);
      user_r_vld = ($urandom_range(0, 99) < 60);
      rxfifo_r_data = 71'({$urandom, $urandom, $urandom});
      user_b_vld = (b_inj < aw_acc) && ($urandom_range(0, 99) < 50);
      rxfifo_b_data = 6'($urandom);
      user_ar_ready = ($urandom_range(0, 99) < 65);
      user_aw_ready = ($urandom_range(0, 99) < 65);
      user_w_ready = ($urandom_range(0, 99) < 65);
      user_rready = ($urandom_range(0, 99) < 65);
      user_bready = ($urandom_range(0, 99) < 65);
      @(negedge clk_wr);
      chan_chk("rnd_ar", q_ar.size(), user_ar_vld, txfifo_ar_data,
               q_ar.size() != 0 ? q_ar[0] : '0, user_arready, q_ar.size() != 2);
      chan_chk("rnd_aw", q_aw.size(), user_aw_vld, txfifo_aw_data,
               q_aw.size() != 0 ? q_aw[0] : '0, user_awready,
               (q_aw.size() != 2) && (cnt_m != MAXO));
      chan_chk("rnd_w", q_w.size(), user_w_vld, txfifo_w_data,
               q_w.size() != 0 ? q_w[0] : '0, user_wready, q_w.size() != 2);
`ifdef RX_SKID_BYPASS_EN
      chk("rnd_r_vld", user_rvalid, user_r_vld);
      chk("rnd_r_data", {user_rresp, user_rlast, user_rdata, user_rid}, rxfifo_r_data);
      chk("rnd_r_rdy", user_r_ready, user_rready);
      chk("rnd_b_vld", user_bvalid, user_b_vld);
      chk("rnd_b_data", {user_bresp, user_bid}, rxfifo_b_data);
`else
      chan_chk("rnd_r", q_r.size(), user_rvalid, {user_rresp, user_rlast, user_rdata, user_rid},
               q_r.size() != 0 ? q_r[0] : '0, user_r_ready, q_r.size() != 2);
      chan_chk("rnd_b", q_b.size(), user_bvalid, {user_bresp, user_bid},
               q_b.size() != 0 ? q_b[0] : '0, user_b_ready, q_b.size() != 2);
`endif
      chk("rnd_cnt", wr_outstd_cnt, cnt_m);

      ar_pop = user_ar_vld & user_ar_ready;  ar_push = user_arvalid & user_arready;
      aw_pop = user_aw_vld & user_aw_ready;  aw_push = user_awvalid & user_awready;
      w_pop  = user_w_vld & user_w_ready;    w_push  = user_wvalid & user_wready;
      r_pop  = user_rvalid & user_rready;    r_push  = user_r_vld & user_r_ready;
      b_pop  = user_bvalid & user_bready;    b_push  = user_b_vld & user_b_ready;
      if (ar_pop) void'(q_ar.pop_front());
      if (aw_pop) void'(q_aw.pop_front());
      if (w_pop)  void'(q_w.pop_front());
      if (ar_push) q_ar.push_back(pk_a(user_arid, user_arsize, user_arlen, user_arburst, user_araddr));
      if (aw_push) q_aw.push_back(pk_a(user_awid, user_awsize, user_awlen, user_awburst, user_awaddr));
      if (w_push)  q_w.push_back({user_wlast, user_wdata, user_wid});
`ifndef RX_SKID_BYPASS_EN
      if (r_pop) void'(q_r.pop_front());
      if (b_pop) void'(q_b.pop_front());
      if (r_push) q_r.push_back(rxfifo_r_data);
      if (b_push) q_b.push_back(rxfifo_b_data);
`endif
      if (aw_push) aw_acc++;
      if (b_push) b_inj++;
      cnt_m = cnt_m + (aw_push ? 1 : 0) - (b_pop ? 1 : 0);
    end
    do_reset();

    // Async reset with buffers full
    user_ar_ready = 0; user_aw_ready = 0; user_rready = 0; user_bready = 0;
    set_aw(4'd9); user_arvalid = 1; user_awvalid = 1; user_r_vld = 1;
    rxfifo_r_data = rv[0].word;
    tick();
    tick();
    chk("ar_full_rdy", user_arready, 0);
    chk("aw_full_vld", user_aw_vld, 1);
    chk("cnt_before_rst", wr_outstd_cnt, 2);
    #2;
    user_arvalid = 0; user_awvalid = 0; user_r_vld = 0;
    rst_wr_n = 0;
    #1;
    chk("arst_ar_vld", user_ar_vld, 0);
    chk("arst_aw_vld", user_aw_vld, 0);
    chk("arst_rvalid", user_rvalid, 0);
    chk("arst_cnt", wr_outstd_cnt, 0);
    chk("arst_aw_data", txfifo_aw_data, 0);
    @(negedge clk_wr);
    rst_wr_n = 1;
    user_rready = 1; user_bready = 1;
    tick();
    chk("post_arready", user_arready, 1);
    chk("post_awready", user_awready, 1);
    chk("post_r_ready", user_r_ready, 1);
    chk("post_b_ready", user_b_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
